// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder: select/scan controls in, registered
// one-hot output and status pulses out.
interface scan_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
);
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   in;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               wrap;
    logic               err;

    modport master (
        output en, mode, in, load, dwell,
        input  out, idx, wrap, err
    );

    modport slave (
        input  en, mode, in, load, dwell,
        output out, idx, wrap, err
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a self-stepping scan mode: each line is held
// for dwell+1 enabled cycles, out-of-range indices raise a one-cycle err pulse.
module scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    scan_decoder_if.slave bus
);

    localparam logic [SEL_W:0]   OUT_LIM = OUT_W[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_W - 1);

    logic [OUT_W-1:0]   out_p0, out_p1;
    logic [SEL_W-1:0]   idx_p0, idx_p1;
    logic [DWELL_W-1:0] cnt_p0, cnt_p1;
    logic               wrap_p0, wrap_p1;
    logic               err_p0, err_p1;
    logic               in_ok, idx_ok;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot = {{(OUT_W-1){1'b0}}, 1'b1} << i;
    endfunction

    // Range checks are done one bit wider so OUT_W == 2**SEL_W is representable.
    assign in_ok  = {1'b0, bus.in} < OUT_LIM;
    assign idx_ok = {1'b0, idx_p1} < OUT_LIM;

    // Stage p0: next-state decision from the current inputs and index/dwell state
    always_comb begin
        idx_p0  = idx_p1;
        cnt_p0  = cnt_p1;
        out_p0  = '0;
        wrap_p0 = 1'b0;
        err_p0  = 1'b0;
        if (bus.en) begin
            if (!bus.mode) begin
                idx_p0 = bus.in;
                cnt_p0 = '0;
                if (in_ok) out_p0 = onehot(bus.in);
                else       err_p0 = 1'b1;
            end else if (bus.load) begin
                if (in_ok) begin
                    idx_p0 = bus.in;
                    cnt_p0 = '0;
                    out_p0 = onehot(bus.in);
                end else begin
                    err_p0 = 1'b1;
                    out_p0 = out_p1;
                end
            end else if (!idx_ok) begin
                // Stale out-of-range index from direct mode: restart the scan at line 0.
                idx_p0 = '0;
                cnt_p0 = '0;
                out_p0 = onehot('0);
                err_p0 = 1'b1;
            end else if (cnt_p1 >= bus.dwell) begin
                cnt_p0 = '0;
                if (idx_p1 == LAST) begin
                    idx_p0  = '0;
                    wrap_p0 = 1'b1;
                end else begin
                    idx_p0 = idx_p1 + SEL_W'(1);
                end
                out_p0 = onehot(idx_p0);
            end else begin
                cnt_p0 = cnt_p1 + DWELL_W'(1);
                out_p0 = onehot(idx_p1);
            end
        end
    end

    // Stage p1: registered outputs and scan state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p1  <= '0;
            idx_p1  <= '0;
            cnt_p1  <= '0;
            wrap_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            out_p1  <= out_p0;
            idx_p1  <= idx_p0;
            cnt_p1  <= cnt_p0;
            wrap_p1 <= wrap_p0;
            err_p1  <= err_p0;
        end
    end

    assign bus.out  = out_p1;
    assign bus.idx  = idx_p1;
    assign bus.wrap = wrap_p1;
    assign bus.err  = err_p1;

endmodule
